// File: rtl/match_controller.sv
// match_controller: game-flow FSM and score keeper for the pong/foosball design.
// Turns the start_game button and one-cycle goal pulses into scores, ball
// motion control (play_en, ball_reset, serve_dir) and match-end status.
// Optional feature macro: START_DEBOUNCE_EN adds a debounce filter on the
// synchronized start_game level (the default build has no filter).
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | after reset, ball frozen, waiting for start_pulse
// S_SERVE     | single cycle, ball_reset pulse re-centres the ball
// S_PLAY      | ball moving, goal pulses update the score
// S_GOAL_HOLD | ball frozen for HOLD_CYCLES cycles after a goal or let
// S_GAME_OVER | match decided, winner shown, start_pulse begins a new match
module match_controller #(
    parameter int WIN_SCORE       = 9,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_game_i,
    input  logic       goal_p1_i,
    input  logic       goal_p2_i,
    output logic [3:0] score1_o,
    output logic [3:0] score2_o,
    output logic       play_en_o,
    output logic       ball_reset_o,
    output logic       serve_dir_o,
    output logic       game_over_o,
    output logic [1:0] winner_o
);

    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]        WIN       = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_GOAL_HOLD,
        S_GAME_OVER
    } state_t;

    // ------------------------------------------------------------------
    // start_game path: synchronizer, optional debounce, rising-edge pulse
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic edge_prev_q;
    logic start_pulse_q;
    logic start_level;

    // Two-flop synchronizer followed by a registered rising-edge detector.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            edge_prev_q   <= 1'b0;
            start_pulse_q <= 1'b0;
        end else begin
            sync1_q       <= start_game_i;
            sync2_q       <= sync1_q;
            edge_prev_q   <= start_level;
            start_pulse_q <= start_level & ~edge_prev_q;
        end
    end

`ifdef START_DEBOUNCE_EN
    localparam int               DBC_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBC_W-1:0] DBC_LOAD = DBC_W'(DEBOUNCE_CYCLES - 1);

    logic             filt_q;
    logic [DBC_W-1:0] dbc_cnt_q;

    // Filtered level follows the synced input only after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement reloads the timer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            filt_q    <= 1'b0;
            dbc_cnt_q <= DBC_LOAD;
        end else if (sync2_q == filt_q) begin
            dbc_cnt_q <= DBC_LOAD;
        end else if (dbc_cnt_q == '0) begin
            filt_q    <= sync2_q;
            dbc_cnt_q <= DBC_LOAD;
        end else begin
            dbc_cnt_q <= dbc_cnt_q - DBC_W'(1);
        end
    end

    assign start_level = filt_q;
`else
    logic unused_dbc;

    assign start_level = sync2_q;
    assign unused_dbc  = ^DEBOUNCE_CYCLES;
`endif

    // ------------------------------------------------------------------
    // Game FSM with registered outputs
    // ------------------------------------------------------------------
    state_t            state_q,      state_d;
    logic [3:0]        score1_q,     score1_d;
    logic [3:0]        score2_q,     score2_d;
    logic              serve_dir_q,  serve_dir_d;
    logic [1:0]        winner_q,     winner_d;
    logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
    logic              play_en_q,    play_en_d;
    logic              ball_reset_q, ball_reset_d;
    logic              game_over_q,  game_over_d;

    // State register and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            score1_q     <= 4'd0;
            score2_q     <= 4'd0;
            serve_dir_q  <= 1'b0;
            winner_q     <= 2'b00;
            hold_cnt_q   <= '0;
            play_en_q    <= 1'b0;
            ball_reset_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            hold_cnt_q   <= hold_cnt_d;
            play_en_q    <= play_en_d;
            ball_reset_q <= ball_reset_d;
            game_over_q  <= game_over_d;
        end
    end

    // Next-state, score and output decode; outputs are derived from the next
    // state so that they line up with the state they describe.
    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_pulse_q) begin
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (goal_p1_i && goal_p2_i) begin
                    // let: nobody scores, serve direction kept
                    state_d    = S_GOAL_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end else if (goal_p1_i) begin
                    score1_d    = score1_q + 4'd1;
                    serve_dir_d = 1'b1;
                    if (score1_d == WIN) begin
                        state_d  = S_GAME_OVER;
                        winner_d = 2'b01;
                    end else begin
                        state_d    = S_GOAL_HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end else if (goal_p2_i) begin
                    score2_d    = score2_q + 4'd1;
                    serve_dir_d = 1'b0;
                    if (score2_d == WIN) begin
                        state_d  = S_GAME_OVER;
                        winner_d = 2'b10;
                    end else begin
                        state_d    = S_GOAL_HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
            end
            S_GOAL_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = S_SERVE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            S_GAME_OVER: begin
                if (start_pulse_q) begin
                    score1_d    = 4'd0;
                    score2_d    = 4'd0;
                    winner_d    = 2'b00;
                    serve_dir_d = 1'b0;
                    state_d     = S_SERVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        play_en_d    = (state_d == S_PLAY);
        ball_reset_d = (state_d == S_SERVE);
        game_over_d  = (state_d == S_GAME_OVER);
    end

    assign score1_o     = score1_q;
    assign score2_o     = score2_q;
    assign play_en_o    = play_en_q;
    assign ball_reset_o = ball_reset_q;
    assign serve_dir_o  = serve_dir_q;
    assign game_over_o  = game_over_q;
    assign winner_o     = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Randomized scoreboard bench for match_controller. A behavioural model of the
// match rules predicts every cycle's outputs; a monitor compares them.
module tb_match_controller;

    localparam int WIN  = 3;
    localparam int HOLD = 4;
    localparam int DBC  = 8;
`ifdef START_DEBOUNCE_EN
    localparam int PIPE = 4;   // edges of the filtered level reach the game 4 clocks later
`else
    localparam int PIPE = 3;   // edges of the raw sampled level reach the game 3 clocks later
`endif

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_HOLD  = 3;
    localparam int M_OVER  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_game;
    logic       goal_p1;
    logic       goal_p2;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       play_en;
    logic       ball_reset;
    logic       serve_dir;
    logic       game_over;
    logic [1:0] winner;

    always #5 clk = ~clk;

    match_controller #(
        .WIN_SCORE      (WIN),
        .HOLD_CYCLES    (HOLD),
        .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_game_i(start_game),
        .goal_p1_i   (goal_p1),
        .goal_p2_i   (goal_p2),
        .score1_o    (score1),
        .score2_o    (score2),
        .play_en_o   (play_en),
        .ball_reset_o(ball_reset),
        .serve_dir_o (serve_dir),
        .game_over_o (game_over),
        .winner_o    (winner)
    );

    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
        logic       play_en;
        logic       ball_reset;
        logic       dir;
        logic       over;
        logic [1:0] winner;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    // reference model state
    int m_mode, m_s1, m_s2, m_win, m_dir, m_hold;
    bit m_last_lvl;
    bit m_filt;
    int m_run;
    bit m_edges[$];

    task automatic model_step(input bit rst, input bit pin, input bit g1, input bit g2);
        bit   st;
        bit   lvl;
        exp_t e;
        if (rst) begin
            m_mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_hold = 0;
            m_last_lvl = 1'b0; m_filt = 1'b0; m_run = 0;
            m_edges.delete();
            for (int i = 0; i < PIPE; i++) m_edges.push_back(1'b0);
        end else begin
            st = m_edges.pop_front();
`ifdef START_DEBOUNCE_EN
            if (pin != m_filt) begin
                m_run++;
                if (m_run == DBC) begin
                    m_filt = pin;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            lvl = m_filt;
`else
            lvl = pin;
`endif
            m_edges.push_back(lvl & ~m_last_lvl);
            m_last_lvl = lvl;

            case (m_mode)
                M_IDLE:  if (st) m_mode = M_SERVE;
                M_SERVE: m_mode = M_PLAY;
                M_PLAY: begin
                    if (g1 && g2) begin
                        m_mode = M_HOLD;
                        m_hold = HOLD;
                    end else if (g1 || g2) begin
                        if (g1) begin m_s1++; m_dir = 1; end
                        else    begin m_s2++; m_dir = 0; end
                        if (m_s1 == WIN)      begin m_mode = M_OVER; m_win = 1; end
                        else if (m_s2 == WIN) begin m_mode = M_OVER; m_win = 2; end
                        else                  begin m_mode = M_HOLD; m_hold = HOLD; end
                    end
                end
                M_HOLD: begin
                    if (m_hold == 1) m_mode = M_SERVE;
                    else             m_hold--;
                end
                M_OVER: begin
                    if (st) begin
                        m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0;
                        m_mode = M_SERVE;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        e.s1         = 4'(m_s1);
        e.s2         = 4'(m_s2);
        e.play_en    = (m_mode == M_PLAY);
        e.ball_reset = (m_mode == M_SERVE);
        e.dir        = m_dir[0];
        e.over       = (m_mode == M_OVER);
        e.winner     = 2'(m_win);
        sb_q.push_back(e);
    endtask

    // monitor: compares DUT outputs against the oldest prediction
    initial begin
        forever begin
            exp_t e;
            exp_t a;
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = {score1, score2, play_en, ball_reset, serve_dir, game_over, winner};
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs cycle %0d: got s1=%0d s2=%0d play=%b brst=%b dir=%b over=%b win=%b, want s1=%0d s2=%0d play=%b brst=%b dir=%b over=%b win=%b",
                             cyc_no, a.s1, a.s2, a.play_en, a.ball_reset, a.dir, a.over, a.winner,
                             e.s1, e.s2, e.play_en, e.ball_reset, e.dir, e.over, e.winner);
                end
            end
        end
    end

    // stimulus
    initial begin
        int pin_left;
        int r;
        reset      = 1'b1;
        start_game = 1'b0;
        goal_p1    = 1'b0;
        goal_p2    = 1'b0;
        pin_left   = 10;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(posedge clk);
            #1;
            cyc_no = cyc;
            model_step(reset, start_game, goal_p1, goal_p2);

            reset = (cyc < 3) || ($urandom_range(0, 999) == 0) ||
                    ((m_mode == M_HOLD) && (m_hold == HOLD - 1) && ($urandom_range(0, 5) == 0));

            if (pin_left == 0) begin
                start_game = ~start_game;
                pin_left   = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 12);
            end else begin
                pin_left--;
            end

            r       = $urandom_range(0, 31);
            goal_p1 = (r < 3) || (r == 6);
            goal_p2 = ((r >= 3) && (r < 6)) || (r == 6);
        end
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
